// File: rtl/matrix_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_io_pkg
// Description : Shared definitions for the matrix stream reader/writer pair:
//               FSM state encoding and the index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_io_pkg;

    // Load/store sequencing states, shared so reader and writer agree.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index width: one bit wider than needed so n itself is representable.
    function automatic int calc_idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_reader_rc_counter.sv
`default_nettype none
// ============================================================================
// Module      : rc_counter
// Description : Row-major (row, col) counter over an n x n matrix. Flags the
//               final position (n-1, n-1) so the owner can stop there.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_counter
    import matrix_io_pkg::*;
#(
    parameter int n     = 4,
    parameter int IDX_W = calc_idx_w(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] c_max = IDX_W'(n - 1);

    assign last = (row == c_max) && (col == c_max);

    // Column advances every increment; row advances on column wrap. Stepping
    // past the final position returns to the origin rather than overrunning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (col == c_max) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_reader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_reader
// Description : Streaming n x n matrix loader. Accepts row-major words over a
//               valid/ready handshake and issues one registered write per
//               word to matrix storage, then signals done.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_reader
    import matrix_io_pkg::*;
#(
    parameter int n     = 4,
    parameter int W     = 32,
    parameter int IDX_W = calc_idx_w(n)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [W-1:0]     value,
    output logic             we,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_start_ok;
    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_col;
    logic             w_last;

    // Status outputs decode straight from the state register, so in_ready has
    // no combinational dependence on in_valid.
    assign in_ready   = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
    assign done       = (r_state == ST_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    rc_counter #(
        .n     (n),
        .IDX_W (IDX_W)
    ) u_rc_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_start_ok),
        .inc  (w_accept),
        .row  (w_row),
        .col  (w_col),
        .last (w_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: FLUSH lets the final write land before done rises.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_LOAD;
            ST_LOAD:  if (w_accept && w_last) w_next_state = ST_FLUSH;
            ST_FLUSH: w_next_state = ST_DONE;
            ST_DONE:  if (w_start_ok) w_next_state = ST_LOAD;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Write port: strobe pulses one cycle per accepted beat; address and data
    // hold their last values between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            i     <= '0;
            j     <= '0;
            value <= '0;
        end else begin
            we <= w_accept;
            if (w_accept) begin
                i     <= w_row;
                j     <= w_col;
                value <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_reader
// Description : Self-checking bench for matrix_reader (n=4 and n=1 instances)
//               against a behavioural load model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_reader;

    localparam int N   = 4;
    localparam int NN  = N * N;
    localparam int IW4 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start4 = 1'b0, valid4 = 1'b0, ready4, we4, busy4, done4;
    logic [31:0]     data4 = '0, value4;
    logic [IW4-1:0]  i4, j4;

    logic            start1 = 1'b0, valid1 = 1'b0, ready1, we1, busy1, done1;
    logic [31:0]     data1 = '0, value1;
    logic [0:0]      i1, j1;

    matrix_reader #(.n(N), .W(32)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_data(data4), .in_valid(valid4),
        .in_ready(ready4), .i(i4), .j(j4), .value(value4), .we(we4),
        .busy(busy4), .done(done4)
    );

    matrix_reader #(.n(1), .W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_data(data1), .in_valid(valid1),
        .in_ready(ready1), .i(i1), .j(j1), .value(value1), .we(we1),
        .busy(busy1), .done(done1)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: phase 0 idle, 1 loading, 2 final write, 3 done.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_i     = 0;
    int          m_j     = 0;
    logic [31:0] m_val   = '0;
    logic [31:0] exp_mem [NN];
    logic [31:0] tb_mem  [NN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle on the n=4 instance with model prediction and checks.
    task automatic cyc4(input logic st, input logic v, input logic [31:0] d);
        int   ph;
        logic acc;
        start4 = st; valid4 = v; data4 = d;
        ph  = m_phase;
        acc = (ph == 1) && v;
        @(posedge clk); #1;
        if (acc) begin
            exp_mem[m_k] = d;
            m_i   = m_k / N;
            m_j   = m_k % N;
            m_val = d;
            m_k++;
        end
        if ((ph == 0 || ph == 3) && st) begin
            m_phase = 1;
            m_k     = 0;
        end else if (ph == 1 && m_k == NN) begin
            m_phase = 2;
        end else if (ph == 2) begin
            m_phase = 3;
        end
        chk("we", {31'd0, we4}, {31'd0, acc});
        chk("i", {29'd0, i4}, m_i);
        chk("j", {29'd0, j4}, m_j);
        chk("value", value4, m_val);
        chk("in_ready", {31'd0, ready4}, (m_phase == 1) ? 1 : 0);
        chk("busy", {31'd0, busy4}, (m_phase == 1 || m_phase == 2) ? 1 : 0);
        chk("done", {31'd0, done4}, (m_phase == 3) ? 1 : 0);
        if (we4 === 1'b1 && i4 < N && j4 < N) tb_mem[i4 * N + j4] = value4;
        start4 = 1'b0; valid4 = 1'b0;
    endtask

    // Asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset();
        rst = 1'b1;
        #2;
        m_phase = 0; m_k = 0; m_i = 0; m_j = 0; m_val = '0;
        chk("rst_we", {31'd0, we4}, 0);
        chk("rst_ij", {26'd0, i4, j4}, 0);
        chk("rst_value", value4, 0);
        chk("rst_status", {29'd0, ready4, busy4, done4}, 0);
        chk("rst_n1", {27'd0, we1, ready1, busy1, done1, i1 | j1}, 0);
        rst = 1'b0;
    endtask

    // Full load: mode 0 continuous base+k, 1 alternating valid, 2 random.
    task automatic load_run(input int mode, input logic [31:0] base);
        logic tog;
        logic v;
        int   cnt;
        tog = 1'b0;
        cnt = 0;
        cyc4(1'b1, 1'b0, 32'd0);
        while (m_phase != 3 && cnt < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin tog = ~tog; v = tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            cyc4(1'b0, v, (mode == 0) ? base + m_k : $urandom);
            cnt++;
        end
        chk("load_done", {31'd0, done4}, 1);
        for (int k = 0; k < NN; k++) chk($sformatf("mem[%0d]", k), tb_mem[k], exp_mem[k]);
    endtask

    initial begin
        for (int k = 0; k < NN; k++) begin
            tb_mem[k]  = '0;
            exp_mem[k] = '0;
        end
        @(posedge clk); #1;
        async_reset();
        cyc4(1'b0, 1'b1, 32'h55);

        // Continuous load with 1..16.
        load_run(0, 32'd1);
        chk("m00", tb_mem[0], 32'd1);
        chk("m03", tb_mem[3], 32'd4);
        chk("m10", tb_mem[4], 32'd5);
        chk("m33", tb_mem[15], 32'd16);

        // Valid outside LOAD is ignored.
        for (int c = 0; c < 3; c++) cyc4(1'b0, 1'b1, $urandom);

        // Alternating valid, then random gaps.
        load_run(1, 32'd0);
        load_run(2, 32'd0);

        // Start mid-load after three words is ignored.
        cyc4(1'b1, 1'b0, 32'd0);
        for (int c = 0; c < 3; c++) cyc4(1'b0, 1'b1, $urandom);
        cyc4(1'b1, 1'b1, $urandom);
        for (int c = 0; c < 40 && m_phase != 3; c++) cyc4(1'b0, 1'b1, $urandom);
        chk("midstart_done", {31'd0, done4}, 1);
        for (int k = 0; k < NN; k++) chk("midstart_mem", tb_mem[k], exp_mem[k]);

        // Reset after five accepted words, then reload from origin.
        cyc4(1'b1, 1'b0, 32'd0);
        for (int c = 0; c < 5; c++) cyc4(1'b0, 1'b1, $urandom);
        async_reset();
        load_run(2, 32'd0);

        // Restart from DONE with 100..115.
        load_run(0, 32'd100);

        // n = 1 instance.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("n1_ready", {30'd0, ready1, busy1}, 32'd3);
        valid1 = 1'b1; data1 = 32'hDEADBEEF;
        @(posedge clk); #1;
        valid1 = 1'b0; data1 = 32'd0;
        chk("n1_we", {29'd0, we1, i1, j1}, 32'd4);
        chk("n1_value", value1, 32'hDEADBEEF);
        chk("n1_flush", {29'd0, ready1, busy1, done1}, 32'd2);
        @(posedge clk); #1;
        chk("n1_done", {29'd0, we1, busy1, done1}, 32'd1);
        chk("n1_hold", value1, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_reader.md
# matrix_reader

Streaming matrix loader: the inbound counterpart of the matrix file writer. It accepts an n×n matrix as a row-major stream of words over a valid/ready handshake. It issues one registered write per word into the shared matrix storage at index (i, j), and raises `done` once the last element has been written. It sits between the input source (file/host model or upstream block) and the matrix array consumed by the multiplier.

## Interface
Parameters:
- `n` — default 4 — matrix dimension (n×n elements); n ≥ 1.
- `W` — default 32 — element width in bits.
- Derived constant `IDX_W` = $clog2(n)+1 — index width, matching the writer's i/j ports.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — begin a load; sampled only in IDLE or DONE.
- `in_data`  in  W  — stream element.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — block accepts an element this cycle.
- `i`  out  IDX_W  — row index of the current write.
- `j`  out  IDX_W  — column index of the current write.
- `value`  out  W  — data for the current write.
- `we`  out  1  — write strobe to matrix storage; one cycle per element.
- `busy`  out  1  — high in LOAD and FLUSH.
- `done`  out  1  — high in DONE; held until the next `start` or reset.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE → LOAD on `start`. Row and column counters are cleared to 0.
- LOAD:
  - `in_ready`=1.
  - A beat is accepted when `in_valid && in_ready`.
  - On each accepted beat, register `value`←`in_data`, `i`←row, `j`←col and `we`←1.
  - Counter advance: col+1. When col==n-1, col wraps to 0 and row increments.
  - When the accepted beat is at (n-1, n-1), go to FLUSH.
- FLUSH: one cycle. `in_ready`=0. The final `we` is presented. Then go to DONE.
- DONE:
  - `done`=1, `in_ready`=0.
  - `start` restarts the load: go to LOAD with counters cleared and `done` dropping.
  - Otherwise stay in DONE.
- `start` in LOAD or FLUSH is ignored.
- `in_valid` outside LOAD is ignored; no element is consumed.
- `we` is 0 in any cycle that has no accepted beat in the previous cycle. `i`/`j`/`value` hold their last values when `we`=0.
- Ordering is strictly row-major: element k lands at (k / n, k mod n).
- Counters never exceed n-1. There is no wrap beyond (n-1, n-1); the FSM leaves LOAD first.
- n=1: the single accepted beat goes directly to FLUSH.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `we`=0, `i`=0, `j`=0, `value`=0, `busy`=0, `done`=0. Counters are 0.
- Reset mid-load aborts immediately. Storage may hold a partial matrix. The next `start` restarts from (0,0).
- `start` in cycle t → `in_ready`=1 in cycle t+1.
- Write latency: a beat accepted at edge t → `we`/`i`/`j`/`value` valid during cycle t+1. Storage captures the write at edge t+1.
- Throughput: one element per cycle under continuous `in_valid`. n² elements plus 2 cycles → `done`.
- Last beat accepted in cycle t:
  - cycle t+1: FLUSH, final `we`, `in_ready`=0.
  - cycle t+2: `done`=1.
- `done` is therefore asserted only after the final write has been captured.
- All outputs are registered or decoded directly from the state register; there is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `matrix_io_pkg`:
  - FSM state encoding (IDLE/LOAD/FLUSH/DONE).
  - `IDX_W` computation function.
  - Both are reused by the writer so index widths match.
- One natural sub-module, `rc_counter`: a row/column counter with parameter `n`, inputs `clr` and `inc`, outputs `row`, `col` and `last` (at (n-1, n-1)). The same counter can later be shared by the writer.

## Test plan
- Full load, n=4, `in_valid` held high with data 1..16 → 16 consecutive `we` pulses. (0,0)=1, (0,3)=4, (1,0)=5, (3,3)=16. `done` is high exactly 2 cycles after the 16th accept. Storage matches row-major order.
- Backpressure gaps, n=4: `in_valid` alternates 1/0 → `we` appears only the cycle after each accept. Order and values are unchanged. Total 16 writes.
- `start` pulsed again mid-LOAD after 3 words → ignored. The sequence continues to (3,3) with no index reset.
- Async reset after 5 accepted words (asserted between edges) → all outputs 0 immediately and state IDLE. A new `start` plus 16 words reloads from (0,0).
- n=1: `start`, then one word 0xDEADBEEF → `we` at (0,0) with 0xDEADBEEF, FLUSH, then `done` 2 cycles after the accept.
- Restart from DONE: second `start` with data 100..115 → `done` drops the next cycle. The matrix is overwritten with 100..115, then `done` reasserts.
